// File: rtl/alu.sv
// Registered single-cycle ALU: eight operations, one result per clock,
// with en_out marking the cycle in which alu_out carries a fresh result.
module alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_in,
    input  logic [2:0]       alu_func,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_out,
    output logic             en_out
);

    // Valid-only handshake: there is no ready. An operation is accepted on every
    // rising edge with en_in=1, and en_out is high for exactly the following
    // cycle. alu_out keeps its last result while en_in is low.

    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_AND = 3'b010;
    localparam logic [2:0] FN_OR  = 3'b011;
    localparam logic [2:0] FN_XOR = 3'b100;
    localparam logic [2:0] FN_SLL = 3'b101;
    localparam logic [2:0] FN_SRL = 3'b110;
    localparam logic [2:0] FN_SLT = 3'b111;

    logic [WIDTH-1:0] result;
    logic [3:0]       shamt;
    logic             a_lt_b;

    // Only the low four bits of alu_b set the shift distance.
    assign shamt  = alu_b[3:0];
    assign a_lt_b = $signed(alu_a) < $signed(alu_b);

    always_comb begin
        result = '0;
        case (alu_func)
            FN_ADD:  result = alu_a + alu_b;
            FN_SUB:  result = alu_a - alu_b;
            FN_AND:  result = alu_a & alu_b;
            FN_OR:   result = alu_a | alu_b;
            FN_XOR:  result = alu_a ^ alu_b;
            FN_SLL:  result = alu_a << shamt;
            FN_SRL:  result = alu_a >> shamt;
            FN_SLT:  result = {{(WIDTH-1){1'b0}}, a_lt_b};
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out <= '0;
            en_out  <= 1'b0;
        end else begin
            en_out <= en_in;
            if (en_in) begin
                alu_out <= result;
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: hand-computed vectors, expected-value queue,
// hold/idle and reset (held and asynchronous mid-stream) scenarios.
module tb_alu;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             en_in;
    logic [2:0]       alu_func;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_out;
    logic             en_out;

    int n_tests;
    int n_fail;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_exp;

    alu #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_in    (en_in),
        .alu_func (alu_func),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_out  (alu_out),
        .en_out   (en_out)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one accepted operation at a falling edge, then check the result one edge later.
    task automatic drive_op(input string tag, input logic [2:0] fn, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
        logic [WIDTH-1:0] e;
        en_in    = 1'b1;
        alu_func = fn;
        alu_a    = a;
        alu_b    = b;
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        last_exp = e;
        check({tag, "_out"}, alu_out, e);
        check({tag, "_en"}, {{(WIDTH-1){1'b0}}, en_out}, 16'h0001);
    endtask

    // Idle cycle with scrambled operands: output must hold, en_out must drop.
    task automatic drive_idle(input string tag);
        en_in    = 1'b0;
        alu_func = 3'($urandom_range(0, 7));
        alu_a    = 16'($urandom_range(0, 16'hFFFF));
        alu_b    = 16'($urandom_range(0, 16'hFFFF));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_hold"}, alu_out, last_exp);
        check({tag, "_en"}, {{(WIDTH-1){1'b0}}, en_out}, 16'h0000);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        last_exp = '0;
        rst_n    = 1'b0;
        en_in    = 1'b1;
        alu_func = 3'b000;
        alu_a    = 16'h1234;
        alu_b    = 16'h4321;

        // Reset held with en_in high: outputs stay cleared across edges.
        for (int i = 0; i < 3; i++) begin
            alu_func = 3'($urandom_range(0, 7));
            alu_a    = 16'($urandom_range(0, 16'hFFFF));
            @(posedge clk);
            @(negedge clk);
            check("rst_out", alu_out, 16'h0000);
            check("rst_en", {{(WIDTH-1){1'b0}}, en_out}, 16'h0000);
        end
        rst_n = 1'b1;

        // Back-to-back operations on the reference operands.
        drive_op("add", 3'b000, 16'h0041, 16'h0021, 16'h0062);
        drive_op("sub", 3'b001, 16'h0041, 16'h0021, 16'h0020);
        drive_op("and", 3'b010, 16'h0041, 16'h0021, 16'h0001);
        drive_op("or",  3'b011, 16'h0041, 16'h0021, 16'h0061);
        drive_op("xor", 3'b100, 16'h0041, 16'h0021, 16'h0060);
        drive_op("sll", 3'b101, 16'h0041, 16'h0021, 16'h0082);
        drive_op("srl", 3'b110, 16'h0041, 16'h0021, 16'h0020);
        drive_op("slt_pos", 3'b111, 16'h0041, 16'h0021, 16'h0000);
        drive_op("slt_neg", 3'b111, 16'h8000, 16'h0001, 16'h0001);
        drive_op("slt_nn",  3'b111, 16'hFFFE, 16'hFFFF, 16'h0001);
        drive_op("slt_eq",  3'b111, 16'h7FFF, 16'h7FFF, 16'h0000);

        // Wrap-around and shift boundaries.
        drive_op("add_wrap", 3'b000, 16'hFFFF, 16'h0001, 16'h0000);
        drive_op("sub_wrap", 3'b001, 16'h0000, 16'h0001, 16'hFFFF);
        drive_op("sub_mix",  3'b001, 16'h1234, 16'h0235, 16'h0FFF);
        drive_op("sll_0",    3'b101, 16'hA5C3, 16'hFFF0, 16'hA5C3);
        drive_op("srl_0",    3'b110, 16'hA5C3, 16'h0030, 16'hA5C3);
        drive_op("sll_15",   3'b101, 16'h8001, 16'h000F, 16'h8000);
        drive_op("srl_15",   3'b110, 16'h8001, 16'hFF2F, 16'h0001);

        // Hold behaviour with en_in dropped for two cycles.
        drive_op("hold_add", 3'b000, 16'h0041, 16'h0021, 16'h0062);
        drive_idle("idle1");
        drive_idle("idle2");

        // Mid-stream asynchronous reset: outputs clear before the next rising edge.
        drive_op("pre_rst", 3'b011, 16'h0F00, 16'h00F0, 16'h0FF0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", alu_out, 16'h0000);
        check("async_rst_en", {{(WIDTH-1){1'b0}}, en_out}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive_op("post_rst", 3'b100, 16'hFFFF, 16'h0F0F, 16'hF0F0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
